// File: rtl/serial_comparator_4bit.sv
`default_nettype none
// ============================================================================
// Module   : serial_comparator_4bit
// Purpose  : Bit-serial unsigned magnitude/equality comparator. Captures two
//            WIDTH-bit operands on an accepted start, compares them one bit
//            per clock MSB first, and reports registered eq/gt/lt results
//            with a start/busy/done handshake.
// Config   : SERIAL_CMP_EARLY_EXIT_EN - when defined, the shift phase ends
//            on the cycle after the first differing bit is found. Result
//            values are identical either way; only the latency changes.
// Revision : 1.0 - initial release
// ============================================================================
module serial_comparator_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  // Counter only has to hold WIDTH-1; one bit is enough for WIDTH=2.
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sha_q, sha_d;
  logic [WIDTH-1:0] shb_q, shb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             decided_q, decided_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;

  // Bits currently under comparison and whether this is the first difference.
  logic             msb_a_w;
  logic             msb_b_w;
  logic             first_diff_w;
  logic             last_bit_w;
  logic             exit_shift_w;

  assign msb_a_w      = sha_q[WIDTH-1];
  assign msb_b_w      = shb_q[WIDTH-1];
  assign first_diff_w = ~decided_q & (msb_a_w ^ msb_b_w);
  assign last_bit_w   = (cnt_q == '0);

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  // Leave SHIFT as soon as the ordering is known, or after the last bit.
  assign exit_shift_w = last_bit_w | first_diff_w;
`else
  // Always walk every bit so the latency is constant.
  assign exit_shift_w = last_bit_w;
`endif

  // Next-state, datapath and result update logic.
  always_comb begin
    state_d   = state_q;
    sha_d     = sha_q;
    shb_d     = shb_q;
    cnt_d     = cnt_q;
    decided_d = decided_q;
    eq_d      = eq_q;
    gt_d      = gt_q;
    lt_d      = lt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sha_d     = A;
          shb_d     = B;
          cnt_d     = C_CNT_LOAD;
          decided_d = 1'b0;
          eq_d      = 1'b0;
          gt_d      = 1'b0;
          lt_d      = 1'b0;
          state_d   = S_SHIFT;
        end
      end

      S_SHIFT: begin
        sha_d = {sha_q[WIDTH-2:0], 1'b0};
        shb_d = {shb_q[WIDTH-2:0], 1'b0};
        // Only the most significant differing bit decides the ordering.
        if (first_diff_w) begin
          decided_d = 1'b1;
          gt_d      = msb_a_w;
          lt_d      = msb_b_w;
        end
        if (exit_shift_w) begin
          // eq is registered on entry to DONE so it holds like gt/lt.
          eq_d    = ~decided_d;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - C_CNT_ONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sha_q     <= '0;
      shb_q     <= '0;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      eq_q      <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sha_q     <= sha_d;
      shb_q     <= shb_d;
      cnt_q     <= cnt_d;
      decided_q <= decided_d;
      eq_q      <= eq_d;
      gt_q      <= gt_d;
      lt_q      <= lt_d;
    end
  end

  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);
  assign eq   = eq_q;
  assign gt   = gt_q;
  assign lt   = lt_q;

endmodule
`default_nettype wire
